// File: rtl/bf_uart_tx_if.sv
// bf_uart_tx_if: byte write handshake from the bf core into the UART transmit FIFO
interface bf_uart_tx_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  modport master (output wr_valid, wr_data, input wr_ready);
  modport slave (input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/bf_uart_tx.sv
// bf_uart_tx: FIFO-buffered 8N1 UART transmitter for bf output; define BF_TX_PARITY_EN to add an even-parity bit
module bf_uart_tx #(
  parameter int DEPTH_LOG2   = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  bf_uart_tx_if.slave         wr,
  output logic                tx,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef BF_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, nxt;
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic tick, push, pop;
`ifdef BF_TX_PARITY_EN
  logic par;
  assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
`else
  assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
  assign wr.wr_ready = level != FULL;
  assign push = wr.wr_valid && wr.wr_ready;
  assign pop = state == IDLE && en && level != '0;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = pop ? START : IDLE;
      START:   nxt = tick ? DATA : START;
`ifdef BF_TX_PARITY_EN
      DATA:    nxt = tick && bit_idx == 3'd7 ? PARITY : DATA;
      PARITY:  nxt = tick ? STOP : PARITY;
`else
      DATA:    nxt = tick && bit_idx == 3'd7 ? STOP : DATA;
`endif
      STOP:    nxt = tick ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef BF_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (wr.wr_valid && !wr.wr_ready) overflow <= 1'b1;
      cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
      if (pop) begin
        shift <= mem[rd_ptr];
`ifdef BF_TX_PARITY_EN
        par   <= ^mem[rd_ptr];
`endif
      end else if (state == DATA && tick) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  // storage is not reset: pointers and level alone define what is valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr.wr_data;
endmodule

// File: tb/tb_bf_uart_tx.sv
// tb_bf_uart_tx: stimulus queues expected bytes; a line monitor decodes tx frames and checks them in order
module tb_bf_uart_tx;
  localparam int CPB = 4;
  localparam int DL  = 2;
`ifdef BF_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR  = NB * CPB;
  localparam int PER = FR + 1;
  logic clk = 1'b0;
  logic rst, en, tx, busy, overflow;
  logic [DL:0] level;
  bf_uart_tx_if wr_if();
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k, n0;
  logic [7:0] exp_q[$];
  int starts[$];
  logic mon_samp [FR];
  bit mon_active = 1'b0;
  int mon_n, mon_bad, mon_p;
  logic [7:0] mon_b, mon_got;
  logic mon_e;
  bf_uart_tx #(.DEPTH_LOG2(DL), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr_if),
    .tx(tx), .busy(busy), .level(level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic push(input logic [7:0] d, input bit queued);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    if (queued) exp_q.push_back(d);
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) mon_active = 1'b0;
    else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_samp[0] = tx;
        mon_n = 1;
        starts.push_back(cyc);
      end
    end else begin
      mon_samp[mon_n] = tx;
      mon_n++;
      if (mon_n == FR) begin
        mon_active = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          mon_b = exp_q.pop_front();
          mon_bad = 0;
          for (int i = 0; i < FR; i++) begin
            mon_p = i / CPB;
            mon_e = mon_p == 0 ? 1'b0 : mon_p <= 8 ? mon_b[mon_p-1] : (NB == 11 && mon_p == 9) ? ^mon_b : 1'b1;
            if (mon_samp[i] !== mon_e) mon_bad++;
          end
          for (int j = 0; j < 8; j++) mon_got[j] = mon_samp[(j+1)*CPB + CPB/2];
          chk("frame_byte", mon_got, mon_b);
          chk("frame_shape", mon_bad, 0);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    en = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data = 8'h99;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_if.wr_ready, 1);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    wr_if.wr_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_push", level, 0);
    chk("rst_idle", busy, 0);
    push(8'h48, 1'b1);
    k = cyc;
    chk("single_level", level, 1);
    chk("single_not_busy", busy, 0);
    @(negedge clk);
    chk("single_start_tx", tx, 0);
    chk("single_busy", busy, 1);
    chk("single_popped", level, 0);
    repeat (FR - 1) @(negedge clk);
    chk("single_busy_end", busy, 1);
    @(negedge clk);
    chk("single_idle", busy, 0);
    chk("single_level_end", level, 0);
    chk("single_start_cycle", starts[$], k + 1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i), 1'b1);
    chk("fill_level", level, 4);
    chk("fill_not_ready", wr_if.wr_ready, 0);
    chk("fill_no_ovf", overflow, 0);
    push(8'h45, 1'b0);
    chk("ovf_level", level, 4);
    chk("ovf_set", overflow, 1);
    n0 = starts.size();
    en = 1'b1;
    @(negedge clk);
    chk("fill_pop_level", level, 3);
    chk("fill_start_tx", tx, 0);
    for (int f = 1; f < 4; f++) begin
      repeat (PER) @(negedge clk);
      chk("fill_level_step", level, 3 - f);
      chk("fill_start_bit", tx, 0);
    end
    repeat (FR + 2) @(negedge clk);
    chk("fill_frames", starts.size() - n0, 4);
    for (int f = 1; f < 4; f++) chk("fill_gap", starts[n0+f] - starts[n0+f-1], PER);
    chk("fill_drained", level, 0);
    chk("ovf_sticky", overflow, 1);
    en = 1'b0;
    push(8'h48, 1'b1);
    en = 1'b1;
    n0 = starts.size();
    push(8'h49, 1'b1);
    chk("cc_level", level, 1);
    chk("cc_busy", busy, 1);
    repeat (2 * PER) @(negedge clk);
    chk("cc_frames", starts.size() - n0, 2);
    chk("cc_gap", starts[n0+1] - starts[n0], PER);
    chk("cc_drained", level, 0);
    en = 1'b0;
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    push(8'h77, 1'b1);
    en = 1'b1;
    @(negedge clk);
    chk("mid_start", tx, 0);
    chk("mid_level", level, 2);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("mid_bit3", tx, 0);
    n0 = starts.size();
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", wr_if.wr_ready, 1);
    chk("mid_rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3 * PER) @(negedge clk);
    chk("mid_no_frame", starts.size(), n0);
    chk("mid_idle_tx", tx, 1);
    push(8'h5A, 1'b1);
    repeat (PER + 2) @(negedge clk);
    chk("mid_new_frame", starts.size(), n0 + 1);
    chk("mid_drained", level, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
